// File: rtl/bf_relax_engine.sv
// Bellman-Ford relaxation engine. Each cycle it relaxes one round-robin (circle
// method) pairing of the nodes in both directions, using N_NODES parallel units.
module bf_relax_engine #(
    parameter int unsigned N_NODES = 4,
    parameter int unsigned DIST_W  = 29,
    parameter int unsigned RND_W   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [N_NODES*DIST_W-1:0]            dist_in,
    input  logic [N_NODES*N_NODES*DIST_W-1:0]    weight_in,
    output logic                                 busy,
    output logic                                 done,
    output logic [N_NODES*DIST_W-1:0]            dist_out,
    output logic [RND_W-1:0]                     rounds_used
);
    localparam int unsigned IDX_W   = $clog2(N_NODES);
    localparam int unsigned WIDX_W  = $clog2(N_NODES * N_NODES);
    localparam int unsigned M       = N_NODES - 1;
    localparam int unsigned N_PAIRS = N_NODES / 2;
    localparam int unsigned N_W     = N_NODES * N_NODES;
    localparam logic [DIST_W-1:0] INF  = '1;
    localparam logic [RND_W-1:0]  LAST = RND_W'(N_NODES - 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DIST_W-1:0]  dist_q   [N_NODES];
    logic [DIST_W-1:0]  weight_q [N_W];
    logic [RND_W-1:0]   step_q;
    logic [RND_W-1:0]   round_q;
    logic               changed_q;

    logic [IDX_W-1:0]   pair_a  [N_PAIRS];
    logic [IDX_W-1:0]   pair_b  [N_PAIRS];
    logic [IDX_W-1:0]   partner [N_NODES];
    logic [DIST_W-1:0]  cand    [N_NODES];
    logic [N_NODES-1:0] upd;
    logic               any_upd;
    logic               last_step;
    logic               finish;
    logic               capture;

    // Maps an offset in 0..2M-2 onto the rotating node ring 1..M.
    function automatic logic [IDX_W-1:0] ring_node(input int unsigned v);
        return IDX_W'(1 + ((v >= M) ? v - M : v));
    endfunction

    // Circle-method schedule: node 0 is fixed, nodes 1..M rotate with the step.
    always_comb begin
        for (int unsigned k = 0; k < N_PAIRS; k++) begin
            pair_a[k] = '0;
            pair_b[k] = '0;
        end
        pair_a[0] = '0;
        pair_b[0] = IDX_W'(32'(step_q) + 1);
        for (int unsigned k = 1; k < N_PAIRS; k++) begin
            pair_a[k] = ring_node(32'(step_q) + k);
            pair_b[k] = ring_node(32'(step_q) + M - k);
        end
    end

    // Every node sits in exactly one pair per step, so it has exactly one source.
    always_comb begin
        for (int unsigned i = 0; i < N_NODES; i++) begin
            partner[i] = IDX_W'(i);
        end
        for (int unsigned k = 0; k < N_PAIRS; k++) begin
            partner[pair_a[k]] = pair_b[k];
            partner[pair_b[k]] = pair_a[k];
        end
    end

    for (genvar t = 0; t < N_NODES; t++) begin : g_relax
        logic [DIST_W-1:0] src_d;
        logic [DIST_W-1:0] edge_w;
        logic [DIST_W:0]   sum;

        assign src_d   = dist_q[partner[t]];
        assign edge_w  = weight_q[WIDX_W'(32'(partner[t]) * N_NODES + t)];
        assign sum     = {1'b0, src_d} + {1'b0, edge_w};
        assign cand[t] = sum[DIST_W-1:0];
        assign upd[t]  = (src_d != INF) && (edge_w != INF) &&
                         (sum < {1'b0, INF}) && (sum[DIST_W-1:0] < dist_q[t]);
    end

    assign any_upd   = |upd;
    assign last_step = (step_q == LAST);
    assign finish    = last_step && (!(changed_q || any_upd) || (round_q == LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    capture = 1'b1;
                end
            end
            RUN: begin
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath, step/round bookkeeping and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            rounds_used <= '0;
            step_q      <= '0;
            round_q     <= '0;
            changed_q   <= 1'b0;
            for (int unsigned i = 0; i < N_NODES; i++) begin
                dist_q[i] <= INF;
            end
            for (int unsigned i = 0; i < N_W; i++) begin
                weight_q[i] <= INF;
            end
        end else begin
            busy <= (state_d != IDLE);
            done <= (state_d == DONE);
            if (capture) begin
                for (int unsigned i = 0; i < N_NODES; i++) begin
                    dist_q[i] <= dist_in[i*DIST_W +: DIST_W];
                end
                for (int unsigned i = 0; i < N_W; i++) begin
                    weight_q[i] <= weight_in[i*DIST_W +: DIST_W];
                end
                step_q    <= '0;
                round_q   <= '0;
                changed_q <= 1'b0;
            end
            if (state_q == RUN) begin
                for (int unsigned t = 0; t < N_NODES; t++) begin
                    if (upd[t]) begin
                        dist_q[t] <= cand[t];
                    end
                end
                if (!last_step) begin
                    step_q    <= step_q + RND_W'(1);
                    changed_q <= changed_q | any_upd;
                end else if (finish) begin
                    rounds_used <= round_q + RND_W'(1);
                end else begin
                    round_q   <= round_q + RND_W'(1);
                    step_q    <= '0;
                    changed_q <= 1'b0;
                end
            end
        end
    end

    for (genvar t = 0; t < N_NODES; t++) begin : g_out
        assign dist_out[t*DIST_W +: DIST_W] = dist_q[t];
    end

endmodule

// File: doc/bf_relax_engine.md
BF_RELAX_ENGINE -- requirements
Module: bf_relax_engine

Interface
REQ-001 Parameter N_NODES, default 4: node count; even, 4..16.
REQ-002 Parameter DIST_W, default 29: distance/weight width; all-ones value is INF.
REQ-003 Parameter RND_W, default 4: rounds_used width; 2^RND_W SHALL be >= N_NODES.
REQ-004 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port start  in  1  request; sampled only in IDLE.
REQ-007 Port dist_in  in  N_NODES*DIST_W  initial distances; node i at bits [i*DIST_W +: DIST_W].
REQ-008 Port weight_in  in  N_NODES*N_NODES*DIST_W  edge weight s->t at index s*N_NODES+t; INF means no edge.
REQ-009 Port busy  out  1  high in RUN and DONE.
REQ-010 Port done  out  1  one-cycle completion pulse.
REQ-011 Port dist_out  out  N_NODES*DIST_W  distance registers, same packing as dist_in.
REQ-012 Port rounds_used  out  RND_W  rounds executed in the last run.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, with registered outputs only.
REQ-014 In IDLE, on start=1: capture dist_in into the distance registers and weight_in into the weight registers; clear step, round and changed; go to RUN.
REQ-015 Each RUN cycle SHALL execute one schedule step s (0..N_NODES-2) using the values the distance registers held before the step.
REQ-016 Schedule, circle method with M=N_NODES-1: pair (0, 1+s); for k=1..N_NODES/2-1, pair (1+((s+k) mod M), 1+((s-k+M) mod M)).
- For N=4: step0 pairs {0,1},{2,3}; step1 pairs {0,2},{3,1}; step2 pairs {0,3},{1,2}.
REQ-017 Each pair (a,b) SHALL relax both directions a->b and b->a in the same cycle, using N_NODES relaxation units in parallel.
REQ-018 Relaxation s->t: candidate = d[s]+w[s][t] computed at DIST_W+1 bits.
- No candidate if d[s]=INF, w=INF, or the sum is >= INF.
- d[t] is updated only if candidate < d[t] (strict).
REQ-019 Any update in a step SHALL set the changed flag.
REQ-020 On the last step of a round (s=N_NODES-2), the FSM SHALL go to DONE if (changed or this step's updates)=0, or if round=N_NODES-2; otherwise it increments round and clears s and changed.
REQ-021 On entry to DONE, rounds_used SHALL be set to round+1.
REQ-022 done SHALL be 1 exactly while in DONE (one cycle); DONE SHALL return to IDLE unconditionally.
REQ-023 Latency: done SHALL rise on the edge R*(N_NODES-1) edges after the start-capture edge, where R is the number of rounds executed.
REQ-024 start in RUN or DONE SHALL be ignored and not queued.
REQ-025 dist_out SHALL always show the distance registers; it holds its final value through IDLE until the next capture.

Reset
REQ-026 rst SHALL force IDLE with busy=0, done=0, rounds_used=0, all distances INF, all weights INF, and step, round and changed cleared.
REQ-027 rst SHALL take priority over start and abort RUN/DONE with no done pulse.

Verification (N=4, DIST_W=29, INF=0x1FFFFFFF)
REQ-028 Chain test: w01=5, w12=3, w23=2, others INF; dist_in={0,INF,INF,INF}; start -> done after 9 edges, dist_out={0,5,8,10}, rounds_used=3.
REQ-029 All weights INF, dist_in={0,INF,INF,INF} -> done after 3 edges, rounds_used=1, dist_out unchanged.
REQ-030 Saturation: d0=0x1FFFFFF0, w01=0x20, d1=INF -> no update. Separately, d0=0, w01=0x1FFFFFFE -> d1=0x1FFFFFFE.
REQ-031 Assert rst on RUN cycle 4 of the chain test -> next cycle busy=0, dist_out all INF, no done pulse. A fresh start then reproduces REQ-028.
REQ-032 start held high through the chain run and the DONE cycle -> exactly one done per capture; the second capture occurs on the first IDLE edge after DONE.
REQ-033 Both directions in one step: w10=1, w01=1, dist_in={INF,0,INF,INF} -> d0=1 after step0, changed set, and the run continues to a second round.
